// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load-unit write-backs into one registered bank write port,
// buffering ALU writes in a 2-entry FIFO with starvation forcing and RAW hazard detection.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        AluValid,
  input  logic [4:0]  AluAddr,
  input  logic [63:0] AluData,
  output logic        AluReady,
  input  logic        MemValid,
  input  logic [4:0]  MemAddr,
  input  logic [63:0] MemData,
  output logic        MemReady,
  output logic        w,
  output logic [4:0]  AddrC,
  output logic [63:0] DataC,
  input  logic [4:0]  RdAddrA,
  input  logic [4:0]  RdAddrB,
  output logic        Stall
);
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0][4:0]   fa_q, fa_d;
  logic [1:0][63:0]  fd_q, fd_d;
  logic [CW-1:0]     sc_q, sc_d;
  logic              w_d;
  logic [4:0]        addr_d;
  logic [63:0]       data_d;
  logic              empty, full, forced, grant_mem, pop, bypass, push, idx;

  function automatic logic hit(input logic [4:0] r, input logic [1:0] n,
                               input logic [4:0] a0, input logic [4:0] a1,
                               input logic wv, input logic [4:0] ac);
    return r != 5'd31 && ((n != 2'd0 && a0 == r) || (n == 2'd2 && a1 == r) || (wv && ac == r));
  endfunction

  assign empty     = cnt_q == 2'd0;
  assign full      = cnt_q == 2'd2;
  assign forced    = sc_q == CW'(STARVE_LIMIT);
  assign AluReady  = !full;
  assign MemReady  = !forced;
  assign grant_mem = !forced && MemValid;
  assign pop       = forced || (!MemValid && !empty);
  assign bypass    = !forced && !MemValid && empty && AluValid;
  assign push      = AluValid && !full && !bypass && AluAddr != 5'd31;
  // Entry 0 is always the head; a push lands just behind whatever survives the pop.
  assign idx       = cnt_q[0] && !pop;
  assign Stall     = hit(RdAddrA, cnt_q, fa_q[0], fa_q[1], w, AddrC) ||
                     hit(RdAddrB, cnt_q, fa_q[0], fa_q[1], w, AddrC);

  always_comb begin
    fa_d = fa_q;
    fd_d = fd_q;
    if (pop) begin
      fa_d[0] = fa_q[1];
      fd_d[0] = fd_q[1];
    end
    if (push) begin
      fa_d[idx] = AluAddr;
      fd_d[idx] = AluData;
    end
    cnt_d  = cnt_q - {1'b0, pop} + {1'b0, push};
    sc_d   = (pop || empty) ? '0 : grant_mem ? sc_q + 1'b1 : sc_q;
    addr_d = pop ? fa_q[0] : grant_mem ? MemAddr : AluAddr;
    data_d = pop ? fd_q[0] : grant_mem ? MemData : AluData;
    w_d    = (pop || grant_mem || bypass) && addr_d != 5'd31;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
      fa_q  <= '0;
      fd_q  <= '0;
      sc_q  <= '0;
      w     <= 1'b0;
      AddrC <= '0;
      DataC <= '0;
    end else begin
      cnt_q <= cnt_d;
      fa_q  <= fa_d;
      fd_q  <= fd_d;
      sc_q  <= sc_d;
      w     <= w_d;
      AddrC <= w_d ? addr_d : AddrC;
      DataC <= w_d ? data_d : DataC;
    end
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3, is the number of consecutive cycles a pending ALU write may lose to the load unit before it is forced through.
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 AluValid / AluAddr / AluData  input  1/5/64  ALU write-back request: valid, destination register, value.
REQ-005 AluReady  output  1  ALU request accepted at the edge where AluValid and AluReady are both 1.
REQ-006 MemValid / MemAddr / MemData  input  1/5/64  load-unit write-back request: valid, destination register, value.
REQ-007 MemReady  output  1  load request accepted at the edge where MemValid and MemReady are both 1.
REQ-008 w / AddrC / DataC  output  1/5/64  registered write port to the register bank; the bank writes at the edge after w rises.
REQ-009 RdAddrA / RdAddrB  input  5/5  decode-stage read addresses used for the hazard check.
REQ-010 Stall  output  1  combinational read-after-write hazard flag.

Function
REQ-011 The block SHALL hold a 2-entry in-order FIFO of pending ALU writes (address + data).
REQ-012 AluReady SHALL equal "FIFO not full"; there is no pass-through when full, even if a pop occurs in the same cycle.
REQ-013 MemReady SHALL be 1 except in a forced cycle (REQ-017).
REQ-014 Grant each cycle, first match wins: forced cycle -> FIFO head; MemValid -> load request; FIFO non-empty -> FIFO head; AluValid with FIFO empty -> ALU request direct (bypass, not pushed); otherwise no grant.
REQ-015 Any accepted ALU request that is not bypassed SHALL be pushed at the same edge. Simultaneous push and pop SHALL be legal when the FIFO is non-full, and FIFO order SHALL be preserved.
REQ-016 Latency: a granted request SHALL load w=1, AddrC and DataC at the acceptance edge N. w SHALL stay 1 for exactly one cycle per grant and be 0 in cycles with no grant. The register bank is updated at edge N+1.
REQ-017 Starvation counter (0..STARVE_LIMIT): increment when the FIFO is non-empty and the load unit is granted; clear on any pop or when the FIFO is empty. When the counter equals STARVE_LIMIT, the next cycle is forced: MemReady=0, the head is granted, and the counter clears.
REQ-018 Accepted requests with address 31 (zero register) SHALL complete the handshake but SHALL NOT be pushed or issued (w stays 0 for that grant). A cycle whose only grant candidate is such a request counts as a grant.
REQ-019 Same-address writes from both sources SHALL NOT be merged; the later-issued write determines the final register value.
REQ-020 Stall SHALL be 1 iff RdAddrA or RdAddrB (excluding 31) equals the address of a valid FIFO entry, or equals AddrC while w=1.
REQ-021 Unaccepted requests SHALL be ignored. Requesters hold valid, address and data stable until they are accepted.

Reset
REQ-022 While Reset=1: FIFO empty, counter=0, w=0, AddrC=0, DataC=0, Stall=0; AluReady=1 and MemReady=1 immediately, independent of Clk.
REQ-023 Reset asserted mid-operation SHALL discard all pending FIFO entries and any in-flight output-register write. No write is issued at or after the reset edge.

Verification
REQ-024 ALU-only: AluValid, AluAddr=5, AluData=0xAA, FIFO empty -> next cycle w=1, AddrC=5, DataC=0xAA; Stall=1 for RdAddrA=5 during that cycle.
REQ-025 Collision: MemValid (addr 3, 0x11) and AluValid (addr 4, 0x22) in the same cycle -> addr 3 written first, addr 4 next cycle; AluReady stays 1.
REQ-026 Backpressure: MemValid held high, 3 ALU requests -> FIFO fills after 2; AluReady=0 on the third until a pop frees an entry.
REQ-027 Starvation: MemValid held high with 1 FIFO entry -> 3 load grants, then one cycle with MemReady=0 and the FIFO head written, then load grants resume.
REQ-028 Zero register: AluValid with AluAddr=31 -> AluReady handshake completes, w stays 0, Stall=0 for RdAddrA=31.
REQ-029 Reset with 2 entries pending -> w=0, AluReady=1, Stall=0 immediately; no further writes after reset deasserts.
